// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-code bundle between the keypad scanner and its neighbours.
// master: the scanner (drives rows and the key code, senses columns).
// slave:  the keypad/lock side (drives columns, consumes the key code).
interface keypad_scanner_if;
  logic [3:0]  row_n;       // active-low row drive, one row at a time
  logic [2:0]  col_n;       // active-low column sense, asynchronous
  logic [11:0] key_onehot;  // debounced one-hot key code, or 0
  logic        key_valid;   // |key_onehot, registered
  logic        key_strobe;  // one-cycle pulse on a new nonzero code

  modport master (
    output row_n,
    output key_onehot,
    output key_valid,
    output key_strobe,
    input  col_n
  );

  modport slave (
    input  row_n,
    input  key_onehot,
    input  key_valid,
    input  key_strobe,
    output col_n
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row scan, column synchronizer, per-scan snapshot,
// scan-level debounce and one-hot key code with a new-key strobe.
// Key bits: 0-9 digits, 10 = '*', 11 = '#'. Multi-key presses commit 0.
module keypad_scanner #(
  parameter int SCAN_DIV       = 8,  // cycles each row is driven, >= 4
  parameter int DEBOUNCE_SCANS = 3   // identical full scans before commit, >= 1
) (
  input logic              clk,
  input logic              reset_n,
  keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] D_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEBOUNCE_SCANS);

  logic [2:0]    col_s1_q, col_s2_q;
  logic [1:0]    r_q, r_d;
  logic [DW-1:0] d_q, d_d;
  logic [3:0]    row_n_q;
  logic [11:0]   acc_q;
  logic [11:0]   cand_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   key_q;
  logic          valid_q;
  logic          strobe_q;

  logic          sample;
  logic [2:0]    pressed;
  logic [11:0]   row_bits;
  logic [11:0]   raw;
  logic [11:0]   commit_val;

  // Two-flop synchronizer for the asynchronous column inputs (idle = high).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_s1_q <= 3'b111;
      col_s2_q <= 3'b111;
    end else begin
      col_s1_q <= kp.col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // Scan counters, snapshot bits of the current row, and debounce next state.
  always_comb begin
    sample  = (d_q == D_LAST);
    d_d     = sample ? '0 : d_q + 1'b1;
    r_d     = sample ? r_q + 2'd1 : r_q;
    pressed = ~col_s2_q;
    row_bits = '0;
    case (r_q)
      2'd0: row_bits[3:1] = pressed;
      2'd1: row_bits[6:4] = pressed;
      2'd2: row_bits[9:7] = pressed;
      default: begin
        row_bits[10] = pressed[0];  // '*'
        row_bits[0]  = pressed[1];  // '0'
        row_bits[11] = pressed[2];  // '#'
      end
    endcase
    raw = acc_q | row_bits;
    if (raw == cand_q) begin
      cnt_d = (cnt_q == C_FULL) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = CW'(1);
    end
    // Only zero or exactly one key is a legal code; anything else reads as 0.
    commit_val = ((raw & (raw - 12'd1)) == 12'd0) ? raw : 12'd0;
  end

  // Row drive: registered so that row_n always matches the row being scanned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q     <= 2'd0;
      d_q     <= '0;
      row_n_q <= 4'b1111;
    end else begin
      r_q     <= r_d;
      d_q     <= d_d;
      row_n_q <= ~(4'b0001 << r_d);
    end
  end

  // Snapshot accumulation per row, then debounce and commit once per full scan.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q    <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (sample) begin
        if (r_q == 2'd3) begin
          acc_q  <= '0;
          cand_q <= raw;
          cnt_q  <= cnt_d;
          if (cnt_d == C_FULL) begin
            key_q    <= commit_val;
            valid_q  <= |commit_val;
            strobe_q <= (commit_val != 12'd0) && (commit_val != key_q);
          end
        end else begin
          acc_q <= raw;
        end
      end
    end
  end

  assign kp.row_n      = row_n_q;
  assign kp.key_onehot = key_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_strobe = strobe_q;

endmodule
